uart_fifo_param: RTL and testbench

- Parametrised successor to the fixed 16x8 UART byte FIFO. Adds configurable width and depth, programmable almost-full and almost-empty flags, a synchronous flush, a peak-level monitor, and an optional drop-on-full overrun mode.
- Sits between the UART RX deserialiser and the AXI-stream/CPU side, and is also used on TX.
- First-word fall-through: `rddata` is valid whenever `rdvalid` is high.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo_ram.sv | 30 +++
 rtl/uart_fifo_param.sv | 125 ++++++++++++
 tb/tb_uart_fifo_param.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART byte FIFO.
//   OVR_CNT_W      : width of the dropped-write counter
//   lvl_w()        : width of an occupancy value able to hold 0..depth
//   fifo_params_ok : legality check for the FIFO parameter set
package uart_pkg;

  localparam int OVR_CNT_W = 16;

  // Occupancy needs one bit more than the pointers so that "full" (== depth)
  // is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit fifo_params_ok(input int data_w, input int depth,
                                        input int af_level, input int ae_level,
                                        input int drop_on_full);
    bit ok;
    ok = (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0);
    ok = ok && (af_level >= 1) && (af_level <= depth);
    ok = ok && (ae_level >= 0) && (ae_level <= depth - 1);
    ok = ok && ((drop_on_full == 0) || (drop_on_full == 1));
    return ok;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the UART FIFO.
//   clk_i   : clock, write on rising edge
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
// Asynchronous read keeps the FIFO first-word fall-through; a registered-output
// RAM can replace this later if the control adds a prefetch stage.
module uart_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_fifo_param.sv
// Parametrised first-word fall-through UART byte FIFO.
//   aclk, areset            : clock, synchronous active-high reset
//   flush                   : clear contents (peak/overrun state kept)
//   wrvalid/wrready/wrdata  : write handshake
//   rdvalid/rdready/rddata  : read handshake, rddata valid while rdvalid
//   empty/full              : level == 0 / level == DEPTH
//   almost_full/almost_empty: level >= AF_LEVEL / level <= AE_LEVEL
//   level                   : current occupancy 0..DEPTH
//   peak_level, peak_clr    : high-water mark, reload with current level
//   overrun, overrun_cnt    : sticky drop flag and saturating drop count
//   ovr_clr                 : clear overrun state
// All status outputs decode registered state only.
module uart_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int AF_LEVEL     = DEPTH - 2,
  parameter int AE_LEVEL     = 2,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      flush,
  input  logic                      wrvalid,
  output logic                      wrready,
  input  logic [DATA_W-1:0]         wrdata,
  output logic                      rdvalid,
  input  logic                      rdready,
  output logic [DATA_W-1:0]         rddata,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic [lvl_w(DEPTH)-1:0]   peak_level,
  input  logic                      peak_clr,
  output logic                      overrun,
  output logic [OVR_CNT_W-1:0]      overrun_cnt,
  input  logic                      ovr_clr
);

  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = lvl_w(DEPTH);
  localparam bit DROP = (DROP_ON_FULL != 0);

  if (!fifo_params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL, DROP_ON_FULL)) begin : g_param_err
    $error("uart_fifo_param: illegal parameter set");
  end

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d, peak_q, peak_d;
  logic                 ovr_q, ovr_d;
  logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic                 write_fire, read_fire, drop, move_wr, move_rd;

  assign empty        = (level_q == '0);
  assign full         = (level_q == LW'(DEPTH));
  assign almost_full  = (level_q >= LW'(AF_LEVEL));
  assign almost_empty = (level_q <= LW'(AE_LEVEL));
  assign rdvalid      = !empty;
  assign wrready      = DROP ? 1'b1 : !full;
  assign level        = level_q;
  assign peak_level   = peak_q;
  assign overrun      = ovr_q;
  assign overrun_cnt  = ovr_cnt_q;

  always_comb begin
    write_fire = wrvalid && wrready && !full;
    read_fire  = rdvalid && rdready;
    // In drop mode a write while full is lost even if a read frees a slot now.
    drop       = DROP && wrvalid && full;
    // Flush overrides any same-cycle data movement.
    move_wr    = write_fire && !flush;
    move_rd    = read_fire && !flush;

    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(move_wr);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(move_rd);
    level_d  = flush ? '0 : level_q + LW'(move_wr) - LW'(move_rd);

    if (peak_clr || (level_d > peak_q)) peak_d = level_d;
    else                                peak_d = peak_q;

    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    if (ovr_clr) begin
      ovr_d     = 1'b0;
      ovr_cnt_d = '0;
    end else if (drop && !flush) begin
      ovr_d = 1'b1;
      if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      peak_q    <= '0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      peak_q    <= peak_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (move_wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (wrdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rddata)
  );

endmodule

// File: tb/tb_uart_fifo_param.sv
// Bench for uart_fifo_param: one backpressure instance (dut0) and one
// drop-on-full instance (dut1) driven with identical stimulus.
module tb_uart_fifo_param;

  logic       aclk = 1'b0;
  logic       areset, flush, wrvalid, rdready, peak_clr, ovr_clr;
  logic [7:0] wrdata;

  logic       wrready0, rdvalid0, empty0, full0, af0, ae0, overrun0;
  logic [7:0] rddata0;
  logic [4:0] level0, peak0;
  logic [15:0] cnt0;
  logic       wrready1, rdvalid1, empty1, full1, af1, ae1, overrun1;
  logic [7:0] rddata1;
  logic [4:0] level1, peak1;
  logic [15:0] cnt1;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb[$];

  always #5 aclk = ~aclk;

  uart_fifo_param #(.DATA_W(8), .DEPTH(16), .DROP_ON_FULL(0)) dut0 (
    .aclk(aclk), .areset(areset), .flush(flush), .wrvalid(wrvalid), .wrready(wrready0),
    .wrdata(wrdata), .rdvalid(rdvalid0), .rdready(rdready), .rddata(rddata0),
    .empty(empty0), .full(full0), .almost_full(af0), .almost_empty(ae0),
    .level(level0), .peak_level(peak0), .peak_clr(peak_clr), .overrun(overrun0),
    .overrun_cnt(cnt0), .ovr_clr(ovr_clr));

  uart_fifo_param #(.DATA_W(8), .DEPTH(16), .DROP_ON_FULL(1)) dut1 (
    .aclk(aclk), .areset(areset), .flush(flush), .wrvalid(wrvalid), .wrready(wrready1),
    .wrdata(wrdata), .rdvalid(rdvalid1), .rdready(rdready), .rddata(rddata1),
    .empty(empty1), .full(full1), .almost_full(af1), .almost_empty(ae1),
    .level(level1), .peak_level(peak1), .peak_clr(peak_clr), .overrun(overrun1),
    .overrun_cnt(cnt1), .ovr_clr(ovr_clr));

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rr;
    int         lvl;
    logic       emp, ful, af, ae;
  } vec_t;
  vec_t tbl[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    areset = 1'b0; flush = 1'b0; wrvalid = 1'b0; rdready = 1'b0;
    peak_clr = 1'b0; ovr_clr = 1'b0;
  endtask

  // One clock with the currently driven inputs; scoreboard follows the
  // backpressure semantics, which dut1 shares for contents.
  task automatic step();
    bit wa, ra;
    wa = wrvalid && (sb.size() < 16) && !flush && !areset;
    ra = rdready && (sb.size() > 0) && !flush && !areset;
    if (!areset) begin
      chk("rdvalid0", rdvalid0, sb.size() > 0);
      chk("rdvalid1", rdvalid1, sb.size() > 0);
    end
    if (ra) begin
      chk("rddata0", rddata0, sb[0]);
      chk("rddata1", rddata1, sb[0]);
      void'(sb.pop_front());
    end
    if (wa) sb.push_back(wrdata);
    if (flush || areset) sb.delete();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    idle();
    wrdata = 8'h00;
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;

    // Reset state
    chk("rst_empty", empty0, 1);     chk("rst_full", full0, 0);
    chk("rst_rdvalid", rdvalid0, 0); chk("rst_ae", ae0, 1);
    chk("rst_af", af0, 0);           chk("rst_level", level0, 0);
    chk("rst_wrready0", wrready0, 1); chk("rst_wrready1", wrready1, 1);
    chk("rst_peak", peak0, 0);       chk("rst_ovr1", overrun1, 0);
    chk("rst_cnt1", cnt1, 0);

    // Fill 0x00..0x0F then drain
    for (int i = 0; i < 32; i++) begin
      int l;
      l = (i < 16) ? i + 1 : 31 - i;
      tbl[i].wv  = (i < 16);
      tbl[i].wd  = 8'(i);
      tbl[i].rr  = (i >= 16);
      tbl[i].lvl = l;
      tbl[i].emp = (l == 0);
      tbl[i].ful = (l == 16);
      tbl[i].af  = (l >= 14);
      tbl[i].ae  = (l <= 2);
    end
    for (int i = 0; i < 32; i++) begin
      idle();
      wrvalid = tbl[i].wv; wrdata = tbl[i].wd; rdready = tbl[i].rr;
      step();
      chk("tbl_level0", level0, tbl[i].lvl);
      chk("tbl_empty0", empty0, tbl[i].emp);
      chk("tbl_full0", full0, tbl[i].ful);
      chk("tbl_af0", af0, tbl[i].af);
      chk("tbl_ae0", ae0, tbl[i].ae);
      chk("tbl_wrready0", wrready0, !tbl[i].ful);
      chk("tbl_level1", level1, tbl[i].lvl);
      chk("tbl_wrready1", wrready1, 1);
    end

    // Wrap-around streaming at level 3
    idle(); wrvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin wrdata = 8'hC0 + 8'(k); step(); end
    rdready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wrdata = 8'(k + 8'h40);
      step();
      chk("wrap_level0", level0, 3);
    end
    wrvalid = 1'b0;
    repeat (3) step();
    chk("wrap_empty0", empty0, 1);

    // Drop-on-full accounting
    idle(); wrvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin wrdata = 8'(i); step(); end
    chk("drop_full0", full0, 1); chk("drop_full1", full1, 1);
    for (int k = 0; k < 3; k++) begin
      wrdata = (k == 0) ? 8'hAA : (k == 1) ? 8'hBB : 8'hCC;
      step();
      chk("drop_wrready0", wrready0, 0);
      chk("drop_wrready1", wrready1, 1);
      chk("drop_ovr1", overrun1, 1);
      chk("drop_cnt1", cnt1, k + 1);
      chk("drop_ovr0", overrun0, 0);
      chk("drop_level1", level1, 16);
    end
    ovr_clr = 1'b1; wrdata = 8'hDD;
    step();
    chk("ovrclr_ovr1", overrun1, 0); chk("ovrclr_cnt1", cnt1, 0);
    idle(); rdready = 1'b1;
    repeat (16) step();
    chk("drop_drained1", empty1, 1);

    // Flush with same-cycle write, peak retained then cleared
    idle(); peak_clr = 1'b1;
    step();
    chk("peakclr0_at0", peak0, 0);
    idle(); wrvalid = 1'b1;
    for (int i = 0; i < 9; i++) begin wrdata = 8'h90 + 8'(i); step(); end
    chk("pre_flush_level", level0, 9); chk("pre_flush_peak", peak0, 9);
    flush = 1'b1; wrdata = 8'h55; rdready = 1'b1;
    step();
    chk("flush_level0", level0, 0); chk("flush_empty0", empty0, 1);
    chk("flush_peak0", peak0, 9);   chk("flush_peak1", peak1, 9);
    chk("flush_level1", level1, 0);
    idle(); peak_clr = 1'b1;
    step();
    chk("peakclr_after_flush", peak0, 0);
    idle(); wrvalid = 1'b1; wrdata = 8'h66;
    step();
    idle(); rdready = 1'b1;
    step();
    chk("flush_post_empty", empty0, 1);

    // Full with simultaneous read and write
    idle(); wrvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin wrdata = 8'h10 + 8'(i); step(); end
    chk("frw_full0", full0, 1); chk("frw_wrready0_pre", wrready0, 0);
    rdready = 1'b1; wrdata = 8'hEE;
    step();
    chk("frw_level0", level0, 15); chk("frw_full0_after", full0, 0);
    chk("frw_wrready0", wrready0, 1); chk("frw_level1", level1, 15);
    chk("frw_ovr1", overrun1, 1);   chk("frw_cnt1", cnt1, 1);
    chk("frw_peak0", peak0, 16);

    // Reset mid-stream at level 7
    idle(); rdready = 1'b1;
    repeat (8) step();
    chk("mid_level0", level0, 7);
    areset = 1'b1; wrvalid = 1'b1; wrdata = 8'h77;
    step();
    idle();
    chk("mrst_level0", level0, 0); chk("mrst_rdvalid0", rdvalid0, 0);
    chk("mrst_cnt1", cnt1, 0);     chk("mrst_ovr1", overrun1, 0);
    chk("mrst_peak0", peak0, 0);   chk("mrst_level1", level1, 0);
    wrvalid = 1'b1; wrdata = 8'h3C;
    step();
    idle();
    chk("mrst_rdvalid_after", rdvalid0, 1);
    chk("mrst_head0", rddata0, 8'h3C);
    rdready = 1'b1;
    step();
    chk("mrst_empty_end", empty0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
